// File: rtl/wb_pkg.sv
// Shared constants, FSM state and FIFO entry types for the register-file write-back unit.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 1 << ADDR_W;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for the write-back unit. With WB_BYPASS_EN defined it also exposes every
// entry in age order (index 0 = head/oldest) plus a valid mask for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = wb_pkg::DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
`ifdef WB_BYPASS_EN
  ,
  output wb_entry_t ord_o [DEPTH],
  output logic [DEPTH-1:0] vld_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= entry_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));

`ifdef WB_BYPASS_EN
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_o[k] = mem_q[rd_q + PW'(k)];
      vld_o[k] = ((PW+1)'(k) < cnt_q);
    end
  end
`endif

endmodule

// File: rtl/reg_wb_unit.sv
// Write-back unit: queues MEM results, drives the register file write port with
// setup/strobe/hold sequencing and tracks pending writes. WB_BYPASS_EN enables forwarding.
module reg_wb_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = wb_pkg::DEPTH,
  parameter int CNT_W = wb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] qry_addr_a,
  input  logic [ADDR_W-1:0] qry_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              fwd_hit_a,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_data
);

  // state  | meaning
  // IDLE   | nothing in flight, waiting for a queued result
  // SETUP  | address/data presented, strobe low
  // STROBE | strobe high, file commits on its rising edge
  // HOLD   | strobe low, address/data held, pending counter retires

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
    logic              busy;
  } port_res_t;

  wb_state_e         state_q, state_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];

  logic      fifo_push, fifo_pop, fifo_empty, fifo_full;
  wb_entry_t fifo_head;
  logic      retire, issue_fire;
  port_res_t res_a, res_b;

`ifdef WB_BYPASS_EN
  wb_entry_t        fifo_ord [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
`endif

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full && (in_addr != ZERO_REG);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .entry_i ('{addr: in_addr, data: in_data}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
`ifdef WB_BYPASS_EN
    ,
    .ord_o   (fifo_ord),
    .vld_o   (fifo_vld)
`endif
  );

  always_comb begin
    state_d   = state_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    fifo_pop  = 1'b0;
    retire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rf_addr_d = fifo_head.addr;
          rf_data_d = fifo_head.data;
          state_d   = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        retire = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rf_addr_d = fifo_head.addr;
          rf_data_d = fifo_head.data;
          state_d   = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rf_write_d = (state_d == STROBE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign rf_write   = rf_write_q;
  assign rf_address = rf_addr_q;
  assign rf_data    = rf_data_q;

  assign issue_ready = (issue_addr == ZERO_REG) || (cnt_q[issue_addr] != '1);
  assign issue_fire  = issue_valid && issue_ready && (issue_addr != ZERO_REG);

  // A retire on a zero counter is dropped, so an issue in that cycle still counts.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      inc = issue_fire && (issue_addr == ADDR_W'(r));
      dec = retire && (rf_addr_q == ADDR_W'(r)) && (cnt_q[r] != '0);
      if (inc && !dec)      cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_W'(1);
      else                  cnt_d[r] = cnt_q[r];
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!rst) cnt_q[r] <= '0;
      else      cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef WB_BYPASS_EN
  wb_entry_t [DEPTH:0] cand;
  logic [DEPTH:0]      cand_vld;

  // Candidate 0 is the in-flight write (oldest), the FIFO tail is the youngest.
  always_comb begin
    cand[0]     = '{addr: rf_addr_q, data: rf_data_q};
    cand_vld[0] = (state_q == SETUP) || (state_q == STROBE);
    for (int k = 0; k < DEPTH; k++) begin
      cand[k+1]     = fifo_ord[k];
      cand_vld[k+1] = fifo_vld[k];
    end
  end

  function automatic port_res_t fwd_lookup(input logic [ADDR_W-1:0] qry,
                                           input wb_entry_t [DEPTH:0] c,
                                           input logic [DEPTH:0] v,
                                           input logic [CNT_W-1:0] cnt);
    port_res_t r;
    int        nm;
    r  = '0;
    nm = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      if (v[k] && (c[k].addr == qry) && (qry != ZERO_REG)) begin
        r.hit  = 1'b1;
        r.data = c[k].data;
        nm++;
      end
    end
    r.busy = (cnt != '0) && (!r.hit || (int'(cnt) > nm));
    return r;
  endfunction

  assign res_a = fwd_lookup(qry_addr_a, cand, cand_vld, cnt_q[qry_addr_a]);
  assign res_b = fwd_lookup(qry_addr_b, cand, cand_vld, cnt_q[qry_addr_b]);
`else
  assign res_a = '{hit: 1'b0, data: '0, busy: (cnt_q[qry_addr_a] != '0)};
  assign res_b = '{hit: 1'b0, data: '0, busy: (cnt_q[qry_addr_b] != '0)};
`endif

  assign busy_a     = res_a.busy;
  assign fwd_hit_a  = res_a.hit;
  assign fwd_data_a = res_a.data;
  assign busy_b     = res_b.busy;
  assign fwd_hit_b  = res_b.hit;
  assign fwd_data_b = res_b.data;

endmodule
